i2c_master_n: RTL and testbench
===============================

I2C_MASTER_N -- requirements
Module: i2c_master_n

Interface
REQ-001 Parameter CLK_DIV, 250, clk_100 cycles per SCL quarter-period; SCL period = 4*CLK_DIV; legal range 2..65535.
REQ-002 Parameter NBYTES, 3, bytes sent after the device-address byte; legal range 1..4.
REQ-003 Parameter DW, 8*(NBYTES+1), derived width of cfg_data; not overridable.
REQ-004 clk_100  input  1  sole clock.
REQ-005 rst_100  input  1  synchronous, active-low reset.
REQ-006 cfg_data  input  DW  transaction word; MSB byte = 7-bit address + R/W bit (bit 0 of that byte, 1 = read); remaining bytes sent MSB-first.
REQ-007 i2c_req  input  1  start request, level, sampled only in IDLE.
REQ-008 i2c_ack  output  1  one-cycle completion pulse.
REQ-009 nack_err  output  1  slave NACK seen in last transaction; valid with i2c_ack, held until next accept.
REQ-010 busy  output  1  high from accept to the cycle of i2c_ack inclusive.
REQ-011 rd_data  output  8  byte read in read mode; valid with i2c_ack, held until next accept.
REQ-012 sclk  output  1  SCL, push-pull.
REQ-013 sda  inout  1  SDA, open-drain: drives 0 or Z.

Function
REQ-014 States IDLE, START, WBIT, WACK, RBIT, MNACK, STOP, DONE.
REQ-015 Quarter tick: free-running divider counting 0..CLK_DIV-1, restarted to 0 on accept; 2-bit phase counter advances on each tick.
REQ-016 IDLE: sclk=1, sda=Z; i2c_req=1 -> latch cfg_data into a shift register, clear nack_err, go START next cycle.
REQ-017 START: SDA falls while SCL high (quarter 1); SCL falls at quarter 3; -> WBIT.
REQ-018 WBIT: SDA changes only while SCL low (quarter 0); SCL high on quarters 1-2; 8 bits MSB-first; -> WACK.
REQ-019 WACK: SDA released; SDA sampled at quarter 2 (mid SCL-high); 1 -> nack_err set, go STOP directly.
REQ-020 After ACK of address byte: R/W=0 -> next data byte in WBIT; R/W=1 -> RBIT, data bytes ignored.
REQ-021 After ACK of byte NBYTES in write mode -> STOP.
REQ-022 RBIT: SDA released; 8 bits sampled at quarter 2, MSB-first, into rd_data; -> MNACK.
REQ-023 MNACK: SDA released for one SCL period (master NACK); -> STOP.
REQ-024 STOP: SDA 0 with SCL low, SCL rises, then SDA released while SCL high, one full quarter of bus-free held; -> DONE.
REQ-025 DONE: i2c_ack=1 for exactly one clk_100 cycle; -> IDLE.
REQ-026 Write transaction length: (NBYTES+1)*9 SCL periods plus START and STOP phases; i2c_ack cycle count exact and deterministic for given parameters.
REQ-027 i2c_req while busy is ignored; no queueing.
REQ-028 i2c_req held high through DONE starts a new transaction on the first IDLE cycle.
REQ-029 cfg_data changes after accept have no effect on the transaction in progress.
REQ-030 Bit and byte counters saturate-free: 3-bit bit count wraps 7->0 only at the byte boundary; byte count width clog2(NBYTES+1).

Reset
REQ-031 rst_100=0 at any clock edge: state IDLE, sclk=1, sda=Z, i2c_ack=0, busy=0, nack_err=0, rd_data=0, counters 0.
REQ-032 Reset mid-transaction aborts immediately without a STOP; bus released the next cycle.

Structure
REQ-033 State encoding enum and quarter-phase constants in shared package i2c_pkg.
REQ-034 One sub-module i2c_tick_gen (divider + phase counter); FSM and shifter in top.

Verification
REQ-035 CLK_DIV=4, NBYTES=3, cfg_data=0x78_30_08_82, slave ACKs all -> bus decodes 0x78,0x30,0x08,0x82; i2c_ack after exact computed cycle count; nack_err=0.
REQ-036 Same, slave NACKs address -> STOP immediately after first ACK slot; i2c_ack pulse; nack_err=1; no data bits on bus.
REQ-037 cfg_data=0x79_xx_xx_xx, slave returns 0xA5 -> rd_data=0xA5, master NACK on 9th bit, STOP, nack_err=0.
REQ-038 i2c_req pulsed during busy, cfg_data changed mid-transaction -> ignored; original bytes on bus; single i2c_ack.
REQ-039 rst_100 low at byte 2 bit 4 -> next cycle sclk=1, sda=Z, busy=0; new request completes normally.
REQ-040 Checker throughout: SDA changes only when SCL low except START/STOP edges; SCL high and low phases each >= 2*CLK_DIV cycles.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write/read master: FSM states and quarter-phase codes.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WBIT,
        ST_WACK,
        ST_RBIT,
        ST_MNACK,
        ST_STOP,
        ST_DONE
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned BYTE_W = 8;

    // SCL is high during the middle two quarters of every bit period
    function automatic logic scl_mid(input logic [1:0] phase);
        return (phase == Q1) || (phase == Q2);
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: free-running divider plus 2-bit SCL phase counter.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk_100,
    input  logic       rst_100,
    input  logic       clear_i,
    output logic       tick_c_o,
    output logic [1:0] phase_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;

    always_comb begin
        tick_c_o = (cnt_q == DIV_W'(CLK_DIV - 1));
        cnt_d    = tick_c_o ? '0 : cnt_q + DIV_W'(1);
        phase_d  = tick_c_o ? phase_q + 2'd1 : phase_q;
        if (clear_i) begin
            cnt_d   = '0;
            phase_d = Q0;
        end
    end

    always_ff @(posedge clk_100) begin
        if (!rst_100) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/i2c_master_n.sv
// I2C master: sends an address byte then NBYTES write bytes, or reads one byte,
// with START/STOP framing on a push-pull SCL and open-drain SDA.
module i2c_master_n
    import i2c_pkg::*;
#(
    parameter int unsigned  CLK_DIV = 250,
    parameter int unsigned  NBYTES  = 3,
    localparam int unsigned DW      = 8 * (NBYTES + 1)
) (
    input  logic              clk_100,
    input  logic              rst_100,
    input  logic [DW-1:0]     cfg_data,
    input  logic              i2c_req,
    output logic              i2c_ack,
    output logic              nack_err,
    output logic              busy,
    output logic [BYTE_W-1:0] rd_data,
    output logic              sclk,
    inout  wire               sda
);

    localparam int unsigned BC_W = $clog2(NBYTES + 1);

    state_e            state_q, state_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic              nack_q, nack_d;
    logic [BYTE_W-1:0] rd_q, rd_d;
    logic              sclk_q, sclk_d;
    logic              sda_low_q, sda_low_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    logic       tick_c;
    logic [1:0] phase;
    logic       accept_c, qend_c, sample_c, sda_in_c;

    assign accept_c = (state_q == ST_IDLE) && i2c_req;
    assign qend_c   = tick_c && (phase == Q3);
    assign sample_c = tick_c && (phase == Q2);
    assign sda_in_c = sda;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_100  (clk_100),
        .rst_100  (rst_100),
        .clear_i  (accept_c),
        .tick_c_o (tick_c),
        .phase_o  (phase)
    );

    always_ff @(posedge clk_100) begin
        if (!rst_100) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every state boundary lands on the end of quarter 3, so phase wraps with it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i2c_req) state_d = ST_START;
            ST_START: if (qend_c) state_d = ST_WBIT;
            ST_WBIT:  if (qend_c && (bit_cnt_q == 3'd7)) state_d = ST_WACK;
            ST_WACK: begin
                if (qend_c) begin
                    if (nack_q) begin
                        state_d = ST_STOP;
                    end else if ((byte_cnt_q == '0) && rw_q) begin
                        state_d = ST_RBIT;
                    end else if (byte_cnt_q == BC_W'(NBYTES)) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_WBIT;
                    end
                end
            end
            ST_RBIT:  if (qend_c && (bit_cnt_q == 3'd7)) state_d = ST_MNACK;
            ST_MNACK: if (qend_c) state_d = ST_STOP;
            ST_STOP:  if (qend_c) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sclk_d    = 1'b1;
        sda_low_d = 1'b0;
        case (state_q)
            ST_START: begin
                sclk_d    = (phase != Q3);
                sda_low_d = (phase != Q0);
            end
            ST_WBIT: begin
                sclk_d    = scl_mid(phase);
                sda_low_d = ~shift_q[DW-1];
            end
            ST_WACK, ST_RBIT, ST_MNACK: sclk_d = scl_mid(phase);
            ST_STOP: begin
                sclk_d    = (phase != Q0);
                sda_low_d = (phase == Q0) || (phase == Q1);
            end
            default: ;
        endcase
        ack_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // Shifter, counters and status; cfg_data is only looked at on accept
    always_comb begin
        shift_d    = shift_q;
        rw_d       = rw_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        nack_d     = nack_q;
        rd_d       = rd_q;
        if (accept_c) begin
            shift_d    = cfg_data;
            rw_d       = cfg_data[DW-8];
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            nack_d     = 1'b0;
        end else begin
            case (state_q)
                ST_WBIT: begin
                    if (qend_c) begin
                        shift_d   = {shift_q[DW-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_WACK: begin
                    if (sample_c && sda_in_c) nack_d = 1'b1;
                    if (qend_c && (state_d == ST_WBIT)) byte_cnt_d = byte_cnt_q + BC_W'(1);
                end
                ST_RBIT: begin
                    if (sample_c) rd_d = {rd_q[BYTE_W-2:0], sda_in_c};
                    if (qend_c) bit_cnt_d = bit_cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100) begin
        if (!rst_100) begin
            shift_q    <= '0;
            rw_q       <= 1'b0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            nack_q     <= 1'b0;
            rd_q       <= '0;
            sclk_q     <= 1'b1;
            sda_low_q  <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            nack_q     <= nack_d;
            rd_q       <= rd_d;
            sclk_q     <= sclk_d;
            sda_low_q  <= sda_low_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign i2c_ack  = ack_q;
    assign nack_err = nack_q;
    assign busy     = busy_q;
    assign rd_data  = rd_q;
    assign sclk     = sclk_q;
    assign sda      = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_n.sv
// Bench for i2c_master_n: behavioural I2C slave/monitor, byte scoreboard, vector table.
module tb_i2c_master_n;

    localparam int CLK_DIV = 4;
    localparam int NBYTES  = 3;
    localparam int DW      = 8 * (NBYTES + 1);
    localparam int PERIOD  = 4 * CLK_DIV;
    localparam int NV      = 7;

    logic          clk_100  = 1'b0;
    logic          rst_100  = 1'b0;
    logic [DW-1:0] cfg_data = '0;
    logic          i2c_req  = 1'b0;
    logic          i2c_ack, nack_err, busy, sclk;
    logic [7:0]    rd_data;
    wire           sda_w;
    logic          slave_low = 1'b0;

    pullup (sda_w);
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    i2c_master_n #(
        .CLK_DIV (CLK_DIV),
        .NBYTES  (NBYTES)
    ) dut (
        .clk_100  (clk_100),
        .rst_100  (rst_100),
        .cfg_data (cfg_data),
        .i2c_req  (i2c_req),
        .i2c_ack  (i2c_ack),
        .nack_err (nack_err),
        .busy     (busy),
        .rd_data  (rd_data),
        .sclk     (sclk),
        .sda      (sda_w)
    );

    always #5 clk_100 = ~clk_100;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Slave model state
    logic [7:0] exp_q[$];
    logic [7:0] ack_en_mask = 8'hFF;
    logic [7:0] rd_byte     = 8'h00;
    int         mon_bit = 0, mon_byte = 0;
    logic [7:0] mon_rx = 8'h00;
    bit         mon_in = 1'b0, mon_read = 1'b0, mon_rise = 1'b0, mon_mnack = 1'b0;
    int         starts = 0, stops = 0, ack_cnt = 0, phase_viol = 0, run_len = 0;
    logic       prev_sclk = 1'b1, prev_sda = 1'b1;

    initial begin
        logic [7:0] eb;
        forever begin
            @(posedge clk_100);
            #1;
            if (!rst_100) begin
                mon_in = 1'b0; mon_rise = 1'b0; slave_low = 1'b0;
                mon_bit = 0; mon_byte = 0; run_len = 0;
            end else begin
                if (i2c_ack) ack_cnt++;
                // SCL high and low phases must each last at least half a period
                if (sclk != prev_sclk) begin
                    if (run_len < 2 * CLK_DIV) phase_viol++;
                    run_len = 1;
                end else begin
                    run_len++;
                end
                if (sclk && prev_sclk && prev_sda && !sda_w) begin
                    starts++;
                    mon_in = 1'b1; mon_bit = 0; mon_byte = 0; mon_read = 1'b0;
                    mon_rise = 1'b0; mon_mnack = 1'b0; slave_low = 1'b0;
                end else if (sclk && prev_sclk && !prev_sda && sda_w) begin
                    stops++;
                    mon_in = 1'b0;
                end else if (mon_in && sclk && !prev_sclk) begin
                    mon_rise = 1'b1;
                    if (mon_bit < 8) mon_rx = {mon_rx[6:0], sda_w};
                    else if (mon_read && mon_byte != 0) mon_mnack = sda_w;
                end else if (mon_in && !sclk && prev_sclk && mon_rise) begin
                    mon_rise = 1'b0;
                    if (mon_bit == 7) begin
                        mon_bit = 8;
                        if (mon_read && mon_byte != 0) begin
                            slave_low = 1'b0;
                        end else begin
                            if (exp_q.size() == 0) begin
                                n_chk++; n_fail++;
                                $display("FAIL sb_unexpected: got byte 0x%02h, required none", mon_rx);
                            end else begin
                                eb = exp_q.pop_front();
                                check("sb_byte", 32'(mon_rx), 32'(eb));
                            end
                            slave_low = ack_en_mask[mon_byte];
                            if (mon_byte == 0) mon_read = mon_rx[0];
                        end
                    end else if (mon_bit == 8) begin
                        mon_bit = 0;
                        mon_byte++;
                        slave_low = (mon_read && mon_byte == 1 && ack_en_mask[0]) ? !rd_byte[7] : 1'b0;
                    end else begin
                        mon_bit++;
                        slave_low = (mon_read && mon_byte != 0) ? !rd_byte[7 - mon_bit] : 1'b0;
                    end
                end
            end
            prev_sclk = sclk;
            prev_sda  = sda_w;
        end
    end

    typedef struct {
        logic [DW-1:0] cfg;
        logic [7:0]    ack_en;
        logic [7:0]    rd_byte;
        bit            is_read;
        int            nbytes;
        logic          exp_nack;
        logic [7:0]    exp_rd;
        int            exp_cycles;
    } vec_t;

    vec_t vecs[NV];

    task automatic push_bytes(input logic [DW-1:0] cfg, input int nb);
        for (int i = 0; i < nb; i++) exp_q.push_back(8'(cfg >> (DW - 8 - 8 * i)));
    endtask

    task automatic run_vec(input vec_t v, input bit disturb);
        int n;
        int s0, p0, a0;
        bit done;
        ack_en_mask = v.ack_en;
        rd_byte     = v.rd_byte;
        push_bytes(v.cfg, v.nbytes);
        s0 = starts; p0 = stops; a0 = ack_cnt;
        @(negedge clk_100);
        cfg_data = v.cfg;
        i2c_req  = 1'b1;
        @(posedge clk_100);
        #1;
        i2c_req = 1'b0;
        check("busy_accept", 32'(busy), 32'd1);
        n = 0; done = 1'b0;
        while (!done && n < 4000) begin
            @(posedge clk_100);
            #1;
            n++;
            if (disturb && n == 100) begin
                i2c_req  = 1'b1;
                cfg_data = ~v.cfg;
            end
            if (disturb && n == 104) i2c_req = 1'b0;
            if (i2c_ack) done = 1'b1;
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: no i2c_ack after %0d cycles, required at %0d", n, v.exp_cycles);
        end else begin
            check("ack_cycles", 32'(n), 32'(v.exp_cycles));
            check("busy_at_ack", 32'(busy), 32'd1);
            check("nack_err", 32'(nack_err), 32'(v.exp_nack));
            if (v.is_read) check("rd_data", 32'(rd_data), 32'(v.exp_rd));
        end
        @(posedge clk_100);
        #1;
        check("ack_one_cycle", 32'(i2c_ack), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        repeat (2 * CLK_DIV) @(posedge clk_100);
        #1;
        check("nack_hold", 32'(nack_err), 32'(v.exp_nack));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("start_count", 32'(starts - s0), 32'd1);
        check("stop_count", 32'(stops - p0), 32'd1);
        check("ack_count", 32'(ack_cnt - a0), 32'd1);
        if (v.is_read) check("master_nack", 32'(mon_mnack), 32'd1);
    endtask

    initial begin
        int n;
        int s0;
        bit done;

        //        cfg            ack    rd     rd?   bytes nack  exp_rd  cycles
        vecs[0] = '{32'h7830_0882, 8'hFF, 8'h00, 1'b0, 4, 1'b0, 8'h00, (2 + 9 * 4) * PERIOD};
        vecs[1] = '{32'h7830_0882, 8'hFE, 8'h00, 1'b0, 1, 1'b1, 8'h00, (2 + 9 * 1) * PERIOD};
        vecs[2] = '{32'h7912_3456, 8'hFF, 8'hA5, 1'b1, 1, 1'b0, 8'hA5, (2 + 9 + 9) * PERIOD};
        vecs[3] = '{32'hA6FF_005A, 8'hFB, 8'h00, 1'b0, 3, 1'b1, 8'h00, (2 + 9 * 3) * PERIOD};
        vecs[4] = '{32'h3D00_FF00, 8'hFF, 8'h3C, 1'b1, 1, 1'b0, 8'h3C, (2 + 9 + 9) * PERIOD};
        vecs[5] = '{32'h0000_0000, 8'hFF, 8'h00, 1'b0, 4, 1'b0, 8'h00, (2 + 9 * 4) * PERIOD};
        vecs[6] = '{32'hFEFF_FFFF, 8'hFF, 8'h00, 1'b0, 4, 1'b0, 8'h00, (2 + 9 * 4) * PERIOD};

        repeat (3) @(posedge clk_100);
        #2;
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_sda", 32'(sda_w), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(i2c_ack), 32'd0);
        check("rst_nack", 32'(nack_err), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        @(negedge clk_100);
        rst_100 = 1'b1;
        repeat (4) @(posedge clk_100);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], 1'b0);

        // Request and cfg change while busy must not disturb the running write
        run_vec(vecs[0], 1'b1);

        // Request held through DONE restarts on the first IDLE cycle
        ack_en_mask = 8'hFF;
        push_bytes(vecs[6].cfg, 4);
        push_bytes(vecs[6].cfg, 4);
        s0 = starts;
        @(negedge clk_100);
        cfg_data = vecs[6].cfg;
        i2c_req  = 1'b1;
        @(posedge clk_100);
        n = 0; done = 1'b0;
        while (!done && n < 4000) begin
            @(posedge clk_100); #1; n++;
            if (i2c_ack) done = 1'b1;
        end
        check("b2b_first_cycles", 32'(n), 32'((2 + 9 * 4) * PERIOD));
        @(posedge clk_100); #1;
        check("b2b_ack_low", 32'(i2c_ack), 32'd0);
        @(posedge clk_100); #1;
        i2c_req = 1'b0;
        check("b2b_busy_restart", 32'(busy), 32'd1);
        n = 2; done = 1'b0;
        while (!done && n < 4000) begin
            @(posedge clk_100); #1; n++;
            if (i2c_ack) done = 1'b1;
        end
        check("b2b_gap", 32'(n), 32'((2 + 9 * 4) * PERIOD + 2));
        repeat (2 * PERIOD) @(posedge clk_100);
        #1;
        check("b2b_sb_drained", 32'(exp_q.size()), 32'd0);
        check("b2b_starts", 32'(starts - s0), 32'd2);
        exp_q.delete();

        // Reset in the middle of byte 2, bit 4 aborts without STOP
        ack_en_mask = 8'hFF;
        push_bytes(vecs[0].cfg, 4);
        @(negedge clk_100);
        cfg_data = vecs[0].cfg;
        i2c_req  = 1'b1;
        @(posedge clk_100); #1;
        i2c_req = 1'b0;
        n = 0;
        while (!(mon_byte == 2 && mon_bit == 4) && n < 2000) begin
            @(posedge clk_100); #1; n++;
        end
        if (n >= 2000) begin
            n_chk++; n_fail++;
            $display("FAIL abort_point: monitor at byte %0d bit %0d, required byte 2 bit 4", mon_byte, mon_bit);
        end
        @(negedge clk_100);
        rst_100 = 1'b0;
        @(posedge clk_100); #2;
        check("abort_sclk", 32'(sclk), 32'd1);
        check("abort_sda", 32'(sda_w), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd", 32'(rd_data), 32'd0);
        check("abort_sb_left", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        @(negedge clk_100);
        rst_100 = 1'b1;
        repeat (4) @(posedge clk_100);
        run_vec(vecs[0], 1'b0);

        check("scl_phase_len", 32'(phase_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
